// File: rtl/uart_pkg.sv
// Shared constants for the parallel-handshake UART responder: frame format,
// default baud divisor, line idle level and the TX/RX state encoding.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 96;
    localparam logic IDLE_LINE          = 1'b1;

    typedef logic [1:0] uart_state_t;

    // Both serial FSMs walk the same four phases of an 8N1 frame.
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; pushes into a full FIFO and pops from an
// empty one are ignored, so the caller need not gate them.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic                 uarti_clk,
    input  logic                 uarti_rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(RX_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge uarti_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_responder.sv
// Device side of the CPU's wrn/rdn UART handshake: buffered 8N1 transmitter
// (THR + TSR) and receiver feeding a small FIFO read back over the data bus.
module uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int RX_DEPTH     = 4
) (
    input  logic       uarti_clk,
    input  logic       uarti_rst,
    input  logic       uarti_wrn,
    input  logic       uarti_rdn,
    input  logic [7:0] uarti_data_in,
    output logic [7:0] uarto_data_out,
    output logic       uarto_data_oe,
    output logic       uarto_data_ready,
    output logic       uarto_tbre,
    output logic       uarto_tsre,
    output logic       uarto_framing_error,
    output logic       uarto_parity_error,
    input  logic       uarti_rxd,
    output logic       uarto_txd
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic wrn_q;
    logic rdn_q;
    logic wr_edge;
    logic rd_edge;

    logic [7:0]  thr;
    logic        thr_full;
    logic [7:0]  tsr;
    logic        tsre;
    uart_state_t tx_state;
    logic [BW-1:0] tx_baud;
    logic [2:0]  tx_bit;
    logic        tx_baud_end;
    logic        tx_load;

    logic        rxd_meta;
    logic        rxd_s;
    logic        rxd_prev;
    uart_state_t rx_state;
    logic [BW-1:0] rx_baud;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_sample;
    logic        rx_push;
    logic        framing_error;

    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        fifo_full;

    assign wr_edge = !wrn_q && uarti_wrn;
    assign rd_edge = !rdn_q && uarti_rdn;

    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            wrn_q <= 1'b1;
            rdn_q <= 1'b1;
        end else begin
            wrn_q <= uarti_wrn;
            rdn_q <= uarti_rdn;
        end
    end

    // THR hands off to TSR either from idle or straight at the end of a stop
    // bit, which is what makes consecutive frames contiguous.
    assign tx_baud_end = (tx_baud == BAUD_LAST);
    assign tx_load     = thr_full &&
                         ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_baud_end));

    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            thr      <= '0;
            thr_full <= 1'b0;
            tsr      <= '0;
            tsre     <= 1'b1;
            tx_state <= ST_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
        end else begin
            if (tx_load) begin
                thr_full <= 1'b0;
                tsr      <= thr;
            end else if (wr_edge && !thr_full) begin
                thr      <= uarti_data_in;
                thr_full <= 1'b1;
            end

            if (tx_state == ST_IDLE) begin
                tx_baud <= '0;
                tx_bit  <= '0;
                if (thr_full) begin
                    tx_state <= ST_START;
                    tsre     <= 1'b0;
                end
            end else begin
                tx_baud <= tx_baud_end ? '0 : tx_baud + BW'(1);
                if (tx_baud_end) begin
                    if (tx_state == ST_START) begin
                        tx_state <= ST_DATA;
                        tx_bit   <= '0;
                    end else if (tx_state == ST_DATA) begin
                        if (tx_bit == BIT_LAST) begin
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end else if (thr_full) begin
                        tx_state <= ST_START;
                    end else begin
                        tx_state <= ST_IDLE;
                        tsre     <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        uarto_txd = IDLE_LINE;
        if (tx_state == ST_START) begin
            uarto_txd = ~IDLE_LINE;
        end else if (tx_state == ST_DATA) begin
            uarto_txd = tsr[tx_bit];
        end
    end

    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            rxd_meta <= IDLE_LINE;
            rxd_s    <= IDLE_LINE;
            rxd_prev <= IDLE_LINE;
        end else begin
            rxd_meta <= uarti_rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // The start phase runs only half a bit so every later sample lands mid-bit.
    assign rx_stop_sample = (rx_state == ST_STOP) && (rx_baud == BAUD_LAST);
    assign rx_push        = rx_stop_sample && rxd_s;

    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            rx_state <= ST_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    rx_baud <= '0;
                    rx_bit  <= '0;
                    if (rxd_prev && !rxd_s) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rxd_s, rx_shift[7:1]};
                        if (rx_bit == BIT_LAST) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
                default: begin
                    if (rx_stop_sample) begin
                        rx_baud  <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_baud <= rx_baud + BW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge uarti_clk or negedge uarti_rst) begin
        if (!uarti_rst) begin
            framing_error <= 1'b0;
        end else if (rx_stop_sample && !rxd_s) begin
            framing_error <= 1'b1;
        end else if (rd_edge && !fifo_empty) begin
            framing_error <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .uarti_clk (uarti_clk),
        .uarti_rst (uarti_rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rd_edge),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign uarto_data_out      = fifo_empty ? 8'h00 : fifo_head;
    assign uarto_data_oe       = ~uarti_rdn;
    assign uarto_data_ready    = ~fifo_empty;
    assign uarto_tbre          = ~thr_full;
    assign uarto_tsre          = tsre;
    assign uarto_framing_error = framing_error;
    assign uarto_parity_error  = 1'b0;

endmodule

// File: tb/tb_uart_responder.sv
// Self-checking bench for uart_responder: a line monitor decodes txd frames,
// and a queue model of the receive FIFO predicts every read and status flag.
module tb_uart_responder;

    localparam int CPB   = 96;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       wrn;
    logic       rdn;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       framing_error;
    logic       parity_error;
    logic       rxd;
    logic       txd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] tx_got[$];
    int         tx_starts[$];
    logic [7:0] rx_model[$];
    logic       fe_model;

    uart_responder #(
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH     (DEPTH)
    ) dut (
        .uarti_clk           (clk),
        .uarti_rst           (rst_n),
        .uarti_wrn           (wrn),
        .uarti_rdn           (rdn),
        .uarti_data_in       (data_in),
        .uarto_data_out      (data_out),
        .uarto_data_oe       (data_oe),
        .uarto_data_ready    (data_ready),
        .uarto_tbre          (tbre),
        .uarto_tsre          (tsre),
        .uarto_framing_error (framing_error),
        .uarto_parity_error  (parity_error),
        .uarti_rxd           (rxd),
        .uarto_txd           (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decodes each frame on txd by sampling at mid-bit, LSB first.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                tx_starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                checkOutput("tx_start_bit", {31'd0, txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                checkOutput("tx_stop_bit", {31'd0, txd}, 32'd1);
                tx_got.push_back(b);
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    task automatic writeByte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        wrn     = 1'b0;
        repeat (2) @(negedge clk);
        wrn = 1'b1;
    endtask

    task automatic waitTxCount(input int n, input int budget);
        for (int i = 0; i < budget && tx_got.size() < n; i++) @(negedge clk);
        checkOutput("tx_frame_count", tx_got.size(), n);
    endtask

    task automatic waitTsre(input int budget);
        for (int i = 0; i < budget && !tsre; i++) @(negedge clk);
        checkOutput("tsre_idle", {31'd0, tsre}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        if (!stop_bit) begin
            fe_model = 1'b1;
        end else if (rx_model.size() < DEPTH) begin
            rx_model.push_back(b);
        end
        checkOutput("rx_data_ready", {31'd0, data_ready}, {31'd0, rx_model.size() != 0});
        checkOutput("rx_framing_error", {31'd0, framing_error}, {31'd0, fe_model});
    endtask

    task automatic readByte();
        logic [7:0] exp;
        logic [7:0] got;
        logic       oe;
        @(negedge clk);
        rdn = 1'b0;
        repeat (2) @(negedge clk);
        got = data_out;
        oe  = data_oe;
        rdn = 1'b1;
        repeat (3) @(negedge clk);
        if (rx_model.size() != 0) begin
            exp      = rx_model.pop_front();
            fe_model = 1'b0;
        end else begin
            exp = 8'h00;
        end
        checkOutput("read_data", {24'd0, got}, {24'd0, exp});
        checkOutput("read_oe", {31'd0, oe}, 32'd1);
        checkOutput("read_oe_release", {31'd0, data_oe}, 32'd0);
        checkOutput("read_data_ready", {31'd0, data_ready}, {31'd0, rx_model.size() != 0});
        checkOutput("read_framing_error", {31'd0, framing_error}, {31'd0, fe_model});
    endtask

    initial begin
        int         base;
        int         seen_tsre;
        logic [7:0] rb;

        rst_n    = 1'b0;
        wrn      = 1'b1;
        rdn      = 1'b1;
        data_in  = 8'h00;
        rxd      = 1'b1;
        fe_model = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("reset_tbre", {31'd0, tbre}, 32'd1);
        checkOutput("reset_tsre", {31'd0, tsre}, 32'd1);
        checkOutput("reset_data_ready", {31'd0, data_ready}, 32'd0);
        checkOutput("reset_data_oe", {31'd0, data_oe}, 32'd0);
        checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
        checkOutput("reset_framing_error", {31'd0, framing_error}, 32'd0);
        checkOutput("parity_error", {31'd0, parity_error}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single transmit frame");
        writeByte(8'h5A);
        @(negedge clk);
        checkOutput("tx1_tbre_busy", {31'd0, tbre}, 32'd0);
        for (int i = 0; i < 3 && !tbre; i++) @(negedge clk);
        checkOutput("tx1_tbre_free", {31'd0, tbre}, 32'd1);
        checkOutput("tx1_txd_start", {31'd0, txd}, 32'd0);
        repeat (CPB * 10 - 50) @(negedge clk);
        checkOutput("tx1_tsre_busy", {31'd0, tsre}, 32'd0);
        waitTsre(100);
        waitTxCount(1, 100);
        checkOutput("tx1_byte", {24'd0, tx_got[0]}, 32'h5A);

        $display("[TB] back-to-back transmit frames");
        base = tx_got.size();
        writeByte(8'hA5);
        for (int i = 0; i < 10 && !tbre; i++) @(negedge clk);
        writeByte(8'h3C);
        @(negedge clk);
        checkOutput("b2b_tbre_held", {31'd0, tbre}, 32'd0);
        writeByte(8'h77);
        seen_tsre = 0;
        for (int i = 0; i < CPB * 25 && tx_got.size() < base + 2; i++) begin
            @(negedge clk);
            if (tsre) seen_tsre = seen_tsre + 1;
        end
        checkOutput("b2b_frame_count", tx_got.size(), base + 2);
        checkOutput("b2b_tsre_low", seen_tsre, 0);
        if (tx_got.size() >= base + 2) begin
            checkOutput("b2b_byte0", {24'd0, tx_got[base]}, 32'hA5);
            checkOutput("b2b_byte1", {24'd0, tx_got[base+1]}, 32'h3C);
            checkOutput("b2b_gap", tx_starts[base+1] - tx_starts[base], CPB * 10);
        end
        waitTsre(200);
        repeat (CPB * 11) @(negedge clk);
        checkOutput("b2b_ignored_write", tx_got.size(), base + 2);

        $display("[TB] random transmit bytes");
        for (int k = 0; k < 3; k++) begin
            rb   = 8'($urandom);
            base = tx_got.size();
            writeByte(rb);
            waitTxCount(base + 1, CPB * 12);
            if (tx_got.size() > base) begin
                checkOutput("rand_tx_byte", {24'd0, tx_got[base]}, {24'd0, rb});
            end
            waitTsre(200);
        end

        $display("[TB] receive and read");
        applyStimulus(8'hC3, 1'b1);
        readByte();

        $display("[TB] receive overflow");
        for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b1);
        for (int k = 0; k < 5; k++) readByte();

        $display("[TB] framing error and glitch");
        applyStimulus(8'h96, 1'b0);
        applyStimulus(8'h4E, 1'b1);
        readByte();
        @(negedge clk);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB * 11) @(negedge clk);
        checkOutput("glitch_data_ready", {31'd0, data_ready}, {31'd0, rx_model.size() != 0});
        checkOutput("glitch_framing_error", {31'd0, framing_error}, {31'd0, fe_model});

        $display("[TB] random receive traffic");
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                readByte();
            end else begin
                applyStimulus(8'($urandom), ($urandom_range(0, 4) != 0));
            end
        end
        while (rx_model.size() != 0) readByte();
        readByte();

        $display("[TB] reset during a frame");
        writeByte(8'h99);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_txd", {31'd0, txd}, 32'd1);
        checkOutput("abort_tbre", {31'd0, tbre}, 32'd1);
        checkOutput("abort_tsre", {31'd0, tsre}, 32'd1);
        checkOutput("abort_data_ready", {31'd0, data_ready}, 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
